// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
//   Load/store port between the core (master) and the memory-side responder
//   (slave). Carries a valid/ready request channel and a valid/ready response
//   channel.
//
//   Request  : req_valid, req_ready, req_wen, req_size, req_addr, req_wdata
//   Response : rsp_valid, rsp_ready, rsp_rdata, rsp_err
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [1:0]      req_size;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_wen, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Memory-side responder for the core's load/store port. Services one request
//   at a time from an internal doubleword array after a programmable latency.
//   Stores merge the addressed byte lanes; loads return data shifted down to
//   the LSBs and zero-filled above the access size. Misaligned or out-of-range
//   accesses return rsp_err=1 with zero data and never write the array.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset
//     bus  - dmem_responder_if.slave (request and response channels)
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;

    // Captured request; the bus may change freely after acceptance.
    logic            wen_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;

    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            accept, do_access, rsp_hs, mem_we;

    logic [XLEN-1:0] mem_q [DEPTH];

    // ------------------------------------------------------------------ FSM
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        do_access = 1'b0;
        rsp_hs    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    // LATENCY==1 still spends its single cycle in WAIT with a
                    // zero count, so rsp_valid always rises LATENCY edges after
                    // the accept edge.
                    accept  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // --------------------------------------------------------- access logic
    logic [AW-1:0]   idx;
    logic [2:0]      off;
    logic            misalign, out_of_range, acc_err;
    logic [7:0]      lanes, be;
    logic [XLEN-1:0] rd_word, shifted, load_data, wsh, merged;

    assign idx          = addr_q[AW+2:3];
    assign off          = addr_q[2:0];
    assign out_of_range = |addr_q[XLEN-1:AW+3];
    assign rd_word      = mem_q[idx];
    assign shifted      = rd_word >> {off, 3'b000};
    assign wsh          = wdata_q << {off, 3'b000};

    always_comb begin
        misalign  = 1'b0;
        lanes     = 8'h01;
        load_data = '0;
        case (size_q)
            2'd0: begin
                lanes     = 8'h01;
                load_data = {{(XLEN-8){1'b0}},  shifted[7:0]};
            end
            2'd1: begin
                misalign  = addr_q[0];
                lanes     = 8'h03;
                load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            end
            2'd2: begin
                misalign  = |addr_q[1:0];
                lanes     = 8'h0F;
                load_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
            end
            default: begin
                misalign  = |addr_q[2:0];
                lanes     = 8'hFF;
                load_data = shifted;
            end
        endcase
    end

    assign acc_err = misalign | out_of_range;
    // Alignment guarantees the shifted lane mask never runs past byte 7.
    assign be      = lanes << off;

    always_comb begin
        for (int b = 0; b < 8; b++) begin
            merged[8*b +: 8] = be[b] ? wsh[8*b +: 8] : rd_word[8*b +: 8];
        end
    end

    assign rdata_d = (acc_err || wen_q) ? '0 : load_data;
    assign err_d   = acc_err;
    // rst gating keeps a clock edge during reset from ever committing a store.
    assign mem_we  = do_access && wen_q && !acc_err && !rst;

    // ------------------------------------------------------------ registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wen_q   <= bus.req_wen;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (do_access) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end else if (rsp_hs) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    // NOTE: the array has no reset; clearing it would need a write port per
    // word, and its contents are defined only by prior stores.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= merged;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
